// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze controller for the five-stage pipeline: resolves load-use,
// taken-branch and data-memory wait hazards, counts events, traps a hung dmem.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       IFID_Rn,
    input  logic [4:0]       IFID_Rm,
    input  logic             id_uses_rm,
    input  logic             IDEX_ldur,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_Rd,
    input  logic             ex_branch_taken,
    input  logic             exmem_mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              freeze;
    logic              load_use;

    assign freeze   = exmem_mem_req & ~dmem_ready;
    assign load_use = IDEX_ldur & IDEX_RegWrite & (IDEX_Rd != 5'd31) &
                      ((IDEX_Rd == IFID_Rn) | (id_uses_rm & (IDEX_Rd == IFID_Rm)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        state_d     = state_q;
        wait_d      = wait_q;
        stall_d     = stall_q;
        flush_d     = flush_q;

        if (state_q == ST_ERROR) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            if (freeze) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
            end

            // wait_q counts freeze edges already taken; the edge seeing
            // WAIT_LAST completes the TIMEOUT-th consecutive freeze cycle.
            if (freeze) begin
                wait_d = wait_q + 1'b1;
                if (state_q == ST_MEM_WAIT && wait_q == WAIT_LAST) state_d = ST_ERROR;
                else                                               state_d = ST_MEM_WAIT;
            end else begin
                wait_d  = '0;
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign mem_timeout = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4)
// with a queue scoreboard fed by the driver and drained by a negedge monitor.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [4:0] IFID_Rn = '0, IFID_Rm = '0, IDEX_Rd = '0;
    logic id_uses_rm = 1'b0, IDEX_ldur = 1'b0, IDEX_RegWrite = 1'b0;
    logic ex_branch_taken = 1'b0, exmem_mem_req = 1'b0, dmem_ready = 1'b1;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_timeout;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .id_uses_rm(id_uses_rm),
        .IDEX_ldur(IDEX_ldur), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_Rd(IDEX_Rd),
        .ex_branch_taken(ex_branch_taken), .exmem_mem_req(exmem_mem_req),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout(mem_timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    // expected word: {ctrl[6:0], stall[3:0], flush[3:0], timeout}
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    // reference model: abstract view of the pipeline controller
    bit m_error   = 0;
    int m_frz_len = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic cyc(input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                       input logic ldur, input logic rw, input logic [4:0] rd,
                       input logic br, input logic req, input logic rdy, input logic rst);
        bit frz, hz;
        logic [6:0] ctl;
        logic [15:0] e;
        @(posedge clk);
        #1;
        IFID_Rn = rn; IFID_Rm = rm; id_uses_rm = urm; IDEX_ldur = ldur;
        IDEX_RegWrite = rw; IDEX_Rd = rd; ex_branch_taken = br;
        exmem_mem_req = req; dmem_ready = rdy; reset_n = ~rst;
        if (rst) begin
            m_error = 0; m_frz_len = 0; m_stalls = 0; m_flushes = 0;
        end
        frz = req && !rdy;
        hz  = ldur && rw && (rd != 31) && ((rd == rn) || (urm && rd == rm));
        // ctl order: pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb
        if (m_error)  ctl = 7'b0000000;
        else if (frz) ctl = 7'b0000000;
        else if (br)  ctl = 7'b1111111;
        else if (hz)  ctl = 7'b0001111;
        else          ctl = 7'b1101011;
        e = {ctl, 4'(m_stalls), 4'(m_flushes), m_error};
        exp_q.push_back(e);
        if (!rst && !m_error) begin
            if (frz) begin
                m_frz_len++;
                if (m_frz_len == TIMEOUT) m_error = 1;
            end else begin
                m_frz_len = 0;
                if (br)      m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
                else if (hz) m_stalls  = (m_stalls  < CMAX) ? m_stalls  + 1 : CMAX;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // monitor: the DUT presents a fresh control word every cycle
    always @(negedge clk) begin
        logic [15:0] e;
        logic [6:0] act_ctl;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cycle++;
            act_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
            n_checks++;
            if (act_ctl !== e[15:9]) begin
                n_fail++;
                $display("FAIL ctrl cycle %0d: got %b expected %b", n_cycle, act_ctl, e[15:9]);
            end
            n_checks++;
            if (stall_cnt !== e[8:5]) begin
                n_fail++;
                $display("FAIL stall_cnt cycle %0d: got %0d expected %0d", n_cycle, stall_cnt, e[8:5]);
            end
            n_checks++;
            if (flush_cnt !== e[4:1]) begin
                n_fail++;
                $display("FAIL flush_cnt cycle %0d: got %0d expected %0d", n_cycle, flush_cnt, e[4:1]);
            end
            n_checks++;
            if (mem_timeout !== e[0]) begin
                n_fail++;
                $display("FAIL mem_timeout cycle %0d: got %b expected %b", n_cycle, mem_timeout, e[0]);
            end
        end
    end

    initial begin
        do_reset();
        idle(2);
        // load-use on Rn, then Rm only with id_uses_rm=0 (no hazard), then with it set
        cyc(5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        // XZR never hazards; RegWrite=0 never hazards
        cyc(5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        // branch with simultaneous load-use: flush only
        cyc(5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        // 3-cycle memory wait over a pending branch, then resume
        for (int i = 0; i < 3; i++) cyc(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        // timeout: freeze 6 cycles, then dmem_ready with a branch still frozen out
        for (int i = 0; i < 6; i++) cyc(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        idle(1);
        // saturation: 20 consecutive load-use events, then 20 flushes
        for (int i = 0; i < 20; i++) cyc(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        do_reset();
        // randomised traffic with hazard-biased register fields
        for (int i = 0; i < 600; i++) begin
            logic [4:0] rd, rn, rm;
            rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            rn = 5'($urandom_range(0, 7));
            rm = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cyc(rn, rm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 49) == 0));
        end
        idle(2);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
